// File: rtl/tb_sup_pkg.sv
// tb_sup_pkg: shared state encoding, counter width and saturating add for the supervisor
package tb_sup_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        DRAIN    = 3'd2,
        FINISHED = 3'd3,
        TIMEOUT  = 3'd4
    } sup_state_e;

    localparam int CYC_W = 32;

    // Adds inc to count and clamps the result at 2**width-1 instead of wrapping
    function automatic logic [CYC_W-1:0] sat_add(input logic [CYC_W-1:0] count,
                                                 input logic [CYC_W-1:0] inc,
                                                 input int width);
        logic [CYC_W:0] sum;
        logic [CYC_W:0] lim;
        sum = {1'b0, count} + {1'b0, inc};
        lim = ((CYC_W+1)'(1) << width) - (CYC_W+1)'(1);
        return (sum > lim) ? lim[CYC_W-1:0] : sum[CYC_W-1:0];
    endfunction

endpackage

// File: rtl/tb_sim_supervisor_xchk.sv
// tb_sup_xchk: one channel's X/Z detector with a sticky error flag and a per-cycle event
module tb_sup_xchk #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              err,
    output logic              evt
);

    assign evt = $isunknown(valid) || (valid === 1'b1 && $isunknown(data));

    // Sticky flag: once a channel has seen an unknown it stays marked until reset
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (evt) err <= 1'b1;
    end

endmodule

// File: rtl/tb_sim_supervisor.sv
// tb_sim_supervisor: run supervisor with X-checks, watchdogs and delayed finish; TB_SUP_FATAL_EN enables simulator reports
module tb_sim_supervisor
    import tb_sup_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int IDLE_TIMEOUT   = 0,
    parameter int FINISH_DELAY   = 5,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     done,
    input  logic                     kick,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [2:0]               state,
    output logic [CYC_W-1:0]         cycle_count,
    output logic [NUM_CH-1:0]        x_err,
    output logic [ERR_CNT_W-1:0]     x_err_count,
    output logic                     timeout,
    output logic                     finish_req
);

`ifdef TB_SUP_FATAL_EN
    localparam bit REPORT = 1'b1;
`else
    localparam bit REPORT = 1'b0;
`endif

    sup_state_e           state_q, state_d;
    logic [CYC_W-1:0]     cycle_q, idle_q, drain_q, n_evt;
    logic [NUM_CH-1:0]    evt;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 timeout_q, finish_q, tot_exp, idle_exp;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tb_sup_xchk #(.DATA_W(DATA_W)) u_xchk (
            .clk  (clk),
            .rst  (rst),
            .valid(ch_valid[i]),
            .data (ch_data[i*DATA_W +: DATA_W]),
            .err  (x_err[i]),
            .evt  (evt[i])
        );
    end

    // Watchdog expiry, X-event sum and next state; expiry outranks done, kick outranks idle expiry
    always_comb begin
        tot_exp  = cycle_q == CYC_W'(TIMEOUT_CYCLES - 1);
        idle_exp = (IDLE_TIMEOUT != 0) && !kick && idle_q == CYC_W'(IDLE_TIMEOUT - 1);
        n_evt    = '0;
        for (int i = 0; i < NUM_CH; i++) n_evt = n_evt + CYC_W'(evt[i]);
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (tot_exp || idle_exp) ? TIMEOUT : done ? DRAIN : RUN;
            DRAIN:   state_d = tot_exp ? TIMEOUT :
                               (drain_q == CYC_W'(FINISH_DELAY - 1)) ? FINISHED : DRAIN;
            default: state_d = state_q;
        endcase
    end

    // State, counters and registered flags; every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cycle_q   <= '0;
            idle_q    <= '0;
            drain_q   <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (state_q == RUN || state_q == DRAIN) cycle_q <= sat_add(cycle_q, CYC_W'(1), CYC_W);
            idle_q    <= (state_q == RUN && !kick) ? idle_q + CYC_W'(1) : '0;
            drain_q   <= (state_q == DRAIN) ? drain_q + CYC_W'(1) : '0;
            err_q     <= ERR_CNT_W'(sat_add(CYC_W'(err_q), n_evt, ERR_CNT_W));
            timeout_q <= timeout_q | (state_d == TIMEOUT);
            finish_q  <= (state_q == DRAIN) && (state_d == FINISHED);
        end
    end

    if (REPORT) begin : g_report
        // Simulator-side reporting of X events and watchdog expiry
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (evt[i]) $error("tb_sup: X detected on channel %0d", i);
                if (state_q != TIMEOUT && state_d == TIMEOUT)
                    $fatal(1, "tb_sup: %s watchdog expired", tot_exp ? "total-run" : "inactivity");
            end
        end
    end

    assign state       = state_q;
    assign cycle_count = cycle_q;
    assign x_err_count = err_q;
    assign timeout     = timeout_q;
    assign finish_req  = finish_q;

endmodule

// File: tb/tb_tb_sim_supervisor.sv
// tb_tb_sim_supervisor: table-driven and hand-sequenced checks of two supervisor configurations
module tb_tb_sim_supervisor;
    import tb_sup_pkg::*;

    localparam int NC = 4;
    localparam int DW = 8;
    localparam int FD = 5;

    logic           clk = 1'b0;
    logic           rst, start, done, kick;
    logic [NC-1:0]  ch_valid;
    logic [NC*DW-1:0] ch_data;
    logic [2:0]     state_a, state_b;
    logic [31:0]    cyc_a, cyc_b;
    logic [NC-1:0]  xe_a, xe_b;
    logic [1:0]     xc_a;
    logic [7:0]     xc_b;
    logic           to_a, to_b, fr_a, fr_b;
    int             total = 0;
    int             bad = 0;
    int             sb[$];

    typedef struct {
        int         d;
        int         done_at;
        int         kick_per;
        int         kick_last;
        int         tmo;
        logic [2:0] st;
        int         t_end;
        logic       to;
    } scen_t;

    always #5 clk = ~clk;

    tb_sim_supervisor #(.NUM_CH(NC), .DATA_W(DW), .TIMEOUT_CYCLES(50), .IDLE_TIMEOUT(0),
                        .FINISH_DELAY(FD), .ERR_CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .done(done), .kick(kick),
        .ch_valid(ch_valid), .ch_data(ch_data), .state(state_a), .cycle_count(cyc_a),
        .x_err(xe_a), .x_err_count(xc_a), .timeout(to_a), .finish_req(fr_a));

    tb_sim_supervisor #(.NUM_CH(NC), .DATA_W(DW), .TIMEOUT_CYCLES(1000), .IDLE_TIMEOUT(8),
                        .FINISH_DELAY(FD), .ERR_CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .done(done), .kick(kick),
        .ch_valid(ch_valid), .ch_data(ch_data), .state(state_b), .cycle_count(cyc_b),
        .x_err(xe_b), .x_err_count(xc_b), .timeout(to_b), .finish_req(fr_b));

    function automatic logic [2:0] g_st(input int d);
        return d != 0 ? state_b : state_a;
    endfunction
    function automatic logic [31:0] g_cyc(input int d);
        return d != 0 ? cyc_b : cyc_a;
    endfunction
    function automatic logic g_to(input int d);
        return d != 0 ? to_b : to_a;
    endfunction
    function automatic logic g_fr(input int d);
        return d != 0 ? fr_b : fr_a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; done = 1'b0; kick = 1'b0;
        ch_valid = '0; ch_data = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic run_scen(input scen_t s, input int idx);
        int t_end = -1;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 150 && t_end < 0; t++) begin
            done = (t == s.done_at);
            kick = s.kick_per > 0 && (t % s.kick_per) == 0 && t <= s.kick_last;
            if (done && t + FD < s.tmo) sb.push_back(t + FD);
            tick();
            if (g_fr(s.d)) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scen%0d finish_unexpected: got finish_req=1 at t=%0d expected 0", idx, t);
                end else chk($sformatf("scen%0d finish_cycle", idx), t, sb.pop_front());
            end
            if (g_st(s.d) == FINISHED || g_st(s.d) == TIMEOUT) t_end = t;
        end
        done = 1'b0;
        kick = 1'b0;
        chk($sformatf("scen%0d end_cycle", idx), t_end, s.t_end);
        chk($sformatf("scen%0d state", idx), g_st(s.d), s.st);
        chk($sformatf("scen%0d timeout", idx), g_to(s.d), s.to);
        chk($sformatf("scen%0d cycle_count", idx), g_cyc(s.d), s.t_end);
        chk($sformatf("scen%0d sb_empty", idx), sb.size(), 0);
        sb.delete();
        tick();
        chk($sformatf("scen%0d finish_single", idx), g_fr(s.d), 0);
        chk($sformatf("scen%0d state_hold", idx), g_st(s.d), s.st);
        chk($sformatf("scen%0d no_xerr", idx), s.d != 0 ? xe_b : xe_a, 0);
    endtask

    initial begin
        scen_t tbl[8];
        logic  probe;
        tbl[0] = '{0, 20, 1, 999, 50,   FINISHED, 25,  1'b0};
        tbl[1] = '{1, 20, 1, 999, 1000, FINISHED, 25,  1'b0};
        tbl[2] = '{0, -1, 1, 999, 50,   TIMEOUT,  50,  1'b1};
        tbl[3] = '{1, -1, 7, 100, 1000, TIMEOUT,  106, 1'b1};
        tbl[4] = '{0, 50, 1, 999, 50,   TIMEOUT,  50,  1'b1};
        tbl[5] = '{0, 46, 1, 999, 50,   TIMEOUT,  50,  1'b1};
        tbl[6] = '{0, 44, 1, 999, 50,   FINISHED, 49,  1'b0};
        tbl[7] = '{1, -1, 0, 0,   1000, TIMEOUT,  8,   1'b1};

        do_reset();
        chk("rst state_a", state_a, IDLE);
        chk("rst state_b", state_b, IDLE);
        chk("rst cyc_a", cyc_a, 0);
        chk("rst to_a", to_a, 0);
        chk("rst fr_a", fr_a, 0);
        chk("rst xe_b", xe_b, 0);
        chk("rst xc_b", xc_b, 0);

        for (int i = 0; i < 8; i++) run_scen(tbl[i], i);

        do_reset();
        done = 1'b1;
        tick();
        chk("done_in_idle_ignored", state_a, IDLE);
        done = 1'b0;
        start = 1'b1;
        tick();
        chk("start_to_run", state_a, RUN);
        chk("run_cyc0", cyc_a, 0);
        tick();
        chk("start_in_run_ignored", state_a, RUN);
        chk("run_cyc1", cyc_a, 1);
        start = 1'b0;
        kick = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("in_drain", state_a, DRAIN);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_drain_rst state", state_a, IDLE);
        chk("mid_drain_rst cyc", cyc_a, 0);
        chk("mid_drain_rst timeout", to_a, 0);
        chk("mid_drain_rst finish", fr_a, 0);
        tick();
        chk("idle_stays_idle", state_a, IDLE);
        kick = 1'b0;

        ch_valid = '1;
        ch_data = 32'hdead_beef;
        tick();
        chk("known_data xe_a", xe_a, 0);
        chk("known_data xc_b", xc_b, 0);

        probe = 1'bx;
        if ($isunknown(probe)) begin
            do_reset();
            ch_valid = 4'b0101;
            ch_data[15:0] = 'x;
            tick();
            chk("x ch0 only xe", xe_b, 4'b0001);
            chk("x ch0 only count", xc_b, 1);
            ch_valid = {1'bx, 3'b001};
            tick();
            chk("x valid3 xe", xe_b, 4'b1001);
            chk("x valid3 count", xc_b, 3);
            do_reset();
            ch_valid = '1;
            ch_data = 'x;
            tick();
            chk("sat first xc_a", xc_a, 3);
            tick();
            chk("sat hold xc_a", xc_a, 3);
            chk("unsat xc_b", xc_b, 8);
            chk("all xe_a", xe_a, 4'b1111);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
